// File: rtl/arm_ldm_pkg.sv
// Shared definitions for the S3 LDM/STM block-transfer sequencer.
`timescale 1ns/1ps

package arm_ldm_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_t;

    // Addressing modes keyed by {P,U}
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } xfer_mode_t;

endpackage

// File: rtl/ldm_stm_prio_enc.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
`timescale 1ns/1ps

module ldm_stm_prio_enc (
    input  logic [15:0] list,
    output logic [3:0]  index,
    output logic        any,
    output logic        one_left
);

    // Scan high to low so the lowest set bit is the final assignment
    always_comb begin
        index = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (list[i-1]) begin
                index = 4'(i - 1);
            end
        end
    end

    assign any      = |list;
    assign one_left = any && ((list & (list - 16'd1)) == '0);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Stage-3 LDM/STM sequencer: walks the register list one transfer per accept, then writes back the base.
`timescale 1ns/1ps

module ldm_stm_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = arm_ldm_pkg::WORD_BYTES
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [15:0]       reg_list_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic              p_in,
    input  logic              u_in,
    input  logic              w_in,
    input  logic              l_in,
    input  logic              mem_ready_in,
    output logic              busy_out,
    output logic              stall_pipe_out,
    output logic              xfer_valid_out,
    output logic [ADDR_W-1:0] xfer_addr_out,
    output logic [3:0]        xfer_reg_out,
    output logic              xfer_load_out,
    output logic              xfer_last_out,
    output logic              wb_valid_out,
    output logic [ADDR_W-1:0] wb_data_out,
    output logic              done_out
);

    import arm_ldm_pkg::*;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    seq_state_t        state_q, state_d;
    logic [15:0]       list_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_q;
    logic              wb_en_q;
    logic              load_q;

    logic [3:0]        cur_idx;
    logic              any_left;
    logic              one_left;

    logic [4:0]        n_regs;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_calc;

    logic              start_ok;
    logic              accept;

    ldm_stm_prio_enc u_prio_enc (
        .list     (list_q),
        .index    (cur_idx),
        .any      (any_left),
        .one_left (one_left)
    );

    always_comb begin
        n_regs = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n_regs = n_regs + 5'(reg_list_in[i]);
        end
    end

    // Transfers always ascend from the lowest address, so decrementing
    // modes start one block-span below the base.
    always_comb begin
        span = ADDR_W'(n_regs) * STEP;
        unique case (xfer_mode_t'({p_in, u_in}))
            MODE_IA: start_addr = base_addr_in;
            MODE_IB: start_addr = base_addr_in + STEP;
            MODE_DA: start_addr = base_addr_in - span + STEP;
            MODE_DB: start_addr = base_addr_in - span;
            default: start_addr = base_addr_in;
        endcase
        wb_calc = u_in ? (base_addr_in + span) : (base_addr_in - span);
    end

    assign start_ok = start_in && (state_q == ST_IDLE);
    assign accept   = (state_q == ST_XFER) && mem_ready_in;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = (reg_list_in != '0) ? ST_XFER : ST_FIN;
                end
            end
            ST_XFER: begin
                if (accept && one_left) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
            wb_en_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                list_q  <= reg_list_in;
                addr_q  <= start_addr;
                wb_q    <= wb_calc;
                wb_en_q <= w_in && (reg_list_in != '0);
                load_q  <= l_in;
            end else if (accept) begin
                list_q <= list_q & (list_q - 16'd1);
                addr_q <= addr_q + STEP;
            end
        end
    end

    always_comb begin
        busy_out       = (state_q == ST_XFER);
        stall_pipe_out = start_in | busy_out;
        xfer_valid_out = busy_out && any_left;
        xfer_addr_out  = xfer_valid_out ? addr_q : '0;
        xfer_reg_out   = xfer_valid_out ? cur_idx : '0;
        xfer_load_out  = xfer_valid_out && load_q;
        xfer_last_out  = xfer_valid_out && one_left;
        done_out       = (state_q == ST_FIN);
        wb_valid_out   = done_out && wb_en_q;
        wb_data_out    = done_out ? wb_q : '0;
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: driver pushes expected transfers, monitor pops on accepts.
`timescale 1ns/1ps

module tb_ldm_stm_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rn;
        logic        ld;
        logic        last;
    } xfer_t;

    typedef struct {
        logic        wbv;
        logic [31:0] wbd;
    } fin_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [15:0] reg_list_in = '0;
    logic [31:0] base_addr_in = '0;
    logic        p_in = 1'b0;
    logic        u_in = 1'b0;
    logic        w_in = 1'b0;
    logic        l_in = 1'b0;
    logic        mem_ready_in = 1'b0;
    logic        busy_out;
    logic        stall_pipe_out;
    logic        xfer_valid_out;
    logic [31:0] xfer_addr_out;
    logic [3:0]  xfer_reg_out;
    logic        xfer_load_out;
    logic        xfer_last_out;
    logic        wb_valid_out;
    logic [31:0] wb_data_out;
    logic        done_out;

    int errors = 0;
    int checks = 0;

    xfer_t exp_x[$];
    fin_t  exp_f[$];

    ldm_stm_sequencer #(
        .ADDR_W     (32),
        .WORD_BYTES (4)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .reg_list_in    (reg_list_in),
        .base_addr_in   (base_addr_in),
        .p_in           (p_in),
        .u_in           (u_in),
        .w_in           (w_in),
        .l_in           (l_in),
        .mem_ready_in   (mem_ready_in),
        .busy_out       (busy_out),
        .stall_pipe_out (stall_pipe_out),
        .xfer_valid_out (xfer_valid_out),
        .xfer_addr_out  (xfer_addr_out),
        .xfer_reg_out   (xfer_reg_out),
        .xfer_load_out  (xfer_load_out),
        .xfer_last_out  (xfer_last_out),
        .wb_valid_out   (wb_valid_out),
        .wb_data_out    (wb_data_out),
        .done_out       (done_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers in ascending order occupy consecutive words
    // starting at the lowest address of the block the mode describes.
    task automatic push_model(input logic [15:0] list, input logic [31:0] base,
                              input logic p, input logic u, input logic w, input logic l);
        int unsigned n;
        int unsigned k;
        logic [31:0] lo;
        xfer_t x;
        fin_t  f;
        n = 0;
        for (int r = 0; r < 16; r++) if (list[r]) n++;
        if (u) lo = base + (p ? 32'd4 : 32'd0);
        else   lo = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (list[r]) begin
                x.addr = lo + 32'(4 * k);
                x.rn   = 4'(r);
                x.ld   = l;
                x.last = (k == n - 1);
                exp_x.push_back(x);
                k++;
            end
        end
        f.wbv = w && (n != 0);
        f.wbd = u ? base + 32'(4 * n) : base - 32'(4 * n);
        exp_f.push_back(f);
    endtask

    // Monitor
    logic  held_v = 1'b0;
    xfer_t held;
    xfer_t cur;
    xfer_t ex;
    fin_t  ef;

    always @(negedge clk) begin
        if (rst_in) begin
            held_v = 1'b0;
        end else begin
            check("stall_pipe", stall_pipe_out, start_in | busy_out);
            if (start_in) check("start_while_busy", busy_out, 0);
            if (wb_valid_out && !done_out) check("wb_without_done", wb_valid_out, 0);
            cur.addr = xfer_addr_out;
            cur.rn   = xfer_reg_out;
            cur.ld   = xfer_load_out;
            cur.last = xfer_last_out;
            if (held_v) begin
                check("hold_valid", xfer_valid_out, 1);
                check("hold_addr", cur.addr, held.addr);
                check("hold_reg", cur.rn, held.rn);
                check("hold_load", cur.ld, held.ld);
                check("hold_last", cur.last, held.last);
            end
            if (xfer_valid_out) begin
                if (mem_ready_in) begin
                    held_v = 1'b0;
                    if (exp_x.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got reg %0d addr 0x%08h expected none", cur.rn, cur.addr);
                    end else begin
                        ex = exp_x.pop_front();
                        check("xfer_addr", cur.addr, ex.addr);
                        check("xfer_reg", cur.rn, ex.rn);
                        check("xfer_load", cur.ld, ex.ld);
                        check("xfer_last", cur.last, ex.last);
                    end
                end else begin
                    held_v = 1'b1;
                    held   = cur;
                end
            end else begin
                held_v = 1'b0;
            end
            if (done_out) begin
                check("fin_busy", busy_out, 0);
                check("fin_pending_xfers", exp_x.size(), 0);
                if (exp_f.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    ef = exp_f.pop_front();
                    check("wb_valid", wb_valid_out, ef.wbv);
                    if (ef.wbv) check("wb_data", wb_data_out, ef.wbd);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_valid"}, xfer_valid_out, 0);
        check({tag, "_addr"}, xfer_addr_out, 0);
        check({tag, "_reg"}, xfer_reg_out, 0);
        check({tag, "_load"}, xfer_load_out, 0);
        check({tag, "_last"}, xfer_last_out, 0);
        check({tag, "_wbv"}, wb_valid_out, 0);
        check({tag, "_wbd"}, wb_data_out, 0);
        check({tag, "_done"}, done_out, 0);
    endtask

    function automatic logic pick_ready(input int mode, input int c);
        if (mode == 1) return 1'($urandom);
        if (mode == 2) return !(c >= 2 && c <= 4);
        return 1'b1;
    endfunction

    // mode: 0 ready always high, 1 random ready, 2 ready low on cycles 2..4
    task automatic run_txn(input logic [15:0] list, input logic [31:0] base,
                           input logic p, input logic u, input logic w, input logic l,
                           input int mode, input int abort_at, input int exp_done);
        int  c;
        bit  seen;
        @(posedge clk); #1;
        push_model(list, base, p, u, w, l);
        start_in     = 1'b1;
        reg_list_in  = list;
        base_addr_in = base;
        p_in = p; u_in = u; w_in = w; l_in = l;
        mem_ready_in = pick_ready(mode, 0);
        c = 0;
        seen = 0;
        while (!seen && c < 200) begin
            @(posedge clk); #1;
            c++;
            start_in     = 1'b0;
            reg_list_in  = 16'($urandom);
            base_addr_in = $urandom;
            p_in = 1'($urandom); u_in = 1'($urandom);
            w_in = 1'($urandom); l_in = 1'($urandom);
            mem_ready_in = pick_ready(mode, c);
            if (done_out) seen = 1;
            if (c == abort_at) begin
                mem_ready_in = 1'b1;
                rst_in = 1'b1;
                @(posedge clk); #1;
                rst_in = 1'b0;
                exp_x.delete();
                exp_f.delete();
                check_all_zero("abort");
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    check("abort_no_done", done_out, 0);
                    check("abort_no_wb", wb_valid_out, 0);
                end
                return;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", c);
        end else if (exp_done > 0) begin
            check("done_cycle", c, exp_done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle");

        run_txn(16'h000F, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1, 5);
        run_txn(16'h8001, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1, 3);
        run_txn(16'h0012, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1, 0, -1, 3);
        run_txn(16'h00F0, 32'h0000_3000, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1, 8);
        run_txn(16'h0000, 32'h0000_4000, 1'b1, 1'b1, 1'b1, 1'b1, 0, -1, 1);
        run_txn(16'h000F, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 0);
        run_txn(16'hFFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1, 17);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] lst;
            lst = 16'($urandom);
            if (t % 4 == 1) lst = lst & 16'($urandom) & 16'($urandom);
            if (t % 10 == 7) lst = '0;
            run_txn(lst, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    (t % 2 == 0) ? 1 : 0, -1, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("end_xfer_queue", exp_x.size(), 0);
        check("end_fin_queue", exp_f.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
